riscv_axi_rd_arb: RTL and testbench

- Shares one AXI4 read channel (AR/R) between two requesters: index 0 is EXU load/store, index 1 is IFU fetch.
- Round-robin arbitration on AR, requester-tagged ARID, RID-based routing of R back to the owner.
- Per-requester outstanding-read counters throttle each requester.
- Sits between riscv_ifu / riscv_exu read ports and the single external read master; single-beat reads only.

---
 rtl/riscv_axi_rd_arb.sv | 167 ++++++++++++++++
 tb/tb_riscv_axi_rd_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_axi_rd_arb.sv
// riscv_axi_rd_arb: shares one AXI4 read channel between the EXU (index 0) and
// the IFU (index 1). AR is round-robin arbitrated through a two-state FSM, ARID
// carries the requester index, and R beats are routed back by RID. Each
// requester has its own outstanding-read counter, which throttles that
// requester only. Reads are always single-beat.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no AR pending; accept a grant from an eligible requester
// ISSUE | m_arvalid high with latched addr/prot/id; wait for m_arready

module riscv_axi_rd_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 4,
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [1:0]          req_arvalid,
    output logic [1:0]          req_arready,
    input  logic [2*ADDR_W-1:0] req_araddr,
    input  logic [5:0]          req_arprot,
    output logic [1:0]          req_rvalid,
    input  logic [1:0]          req_rready,
    output logic [DATA_W-1:0]   req_rdata,
    output logic [1:0]          req_rresp,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic [ID_W-1:0]     m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    output logic [2*CW-1:0]     outstanding,
    output logic                err
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    state_t              state_q;
    logic                m_arvalid_q;
    logic [ADDR_W-1:0]   m_araddr_q;
    logic [2:0]          m_arprot_q;
    logic [ID_W-1:0]     m_arid_q;
    logic                gnt_q;
    logic                rr_ptr_q;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [1:0] elig;
    logic       gnt_any;
    logic       gnt_idx;
    logic       ar_hs;
    logic       r_own;
    logic       r_ok;
    logic       r_hs;

    assign elig[0] = req_arvalid[0] && (cnt_q[0] < MAX_CNT);
    assign elig[1] = req_arvalid[1] && (cnt_q[1] < MAX_CNT);
    // Grant is gated by reset so req_arready reads 0 while reset is held.
    assign gnt_any = ARESETn && (state_q == IDLE) && (|elig);
    assign gnt_idx = (&elig) ? rr_ptr_q : elig[1];
    assign req_arready = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    assign ar_hs = m_arvalid_q && m_arready;

    assign m_arvalid = m_arvalid_q;
    assign m_araddr  = m_araddr_q;
    assign m_arprot  = m_arprot_q;
    assign m_arid    = m_arid_q;
    assign m_arlen   = 8'd0;
    assign m_arsize  = 3'($clog2(DATA_W / 8));
    assign m_arburst = 2'b01;

    // Upper RID bits must be zero; a shift keeps this valid when ID_W is 1.
    assign r_own = m_rid[0];
    assign r_ok  = ((m_rid >> 1) == '0) && (cnt_q[r_own] != '0);

    assign req_rdata = m_rdata;
    assign req_rresp = m_rresp;

    // Route R to its owner; unexpected beats are sunk so the slave never stalls.
    always_comb begin
        req_rvalid = 2'b00;
        m_rready   = 1'b1;
        if (r_ok) begin
            req_rvalid[r_own] = m_rvalid;
            m_rready          = req_rready[r_own];
        end
    end

    assign r_hs = m_rvalid && m_rready;

    // Next counter values: simultaneous issue and completion cancel out.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ar_hs && (gnt_q == 1'(i)) && !(r_hs && r_ok && (r_own == 1'(i)))) begin
                if (cnt_q[i] != MAX_CNT) cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (r_hs && r_ok && (r_own == 1'(i)) && !(ar_hs && (gnt_q == 1'(i)))) begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    assign err_d = err_q || (m_rvalid && !r_ok) || (r_hs && !m_rlast);

    // AR FSM: latch the winner's request in IDLE, hold it on the bus in ISSUE.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= '0;
            m_arprot_q  <= '0;
            m_arid_q    <= '0;
            gnt_q       <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        m_araddr_q  <= gnt_idx ? req_araddr[2*ADDR_W-1:ADDR_W] : req_araddr[ADDR_W-1:0];
                        m_arprot_q  <= gnt_idx ? req_arprot[5:3] : req_arprot[2:0];
                        m_arid_q    <= ID_W'(gnt_idx);
                        gnt_q       <= gnt_idx;
                        m_arvalid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_arready) begin
                        m_arvalid_q <= 1'b0;
                        rr_ptr_q    <= ~gnt_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outstanding counters and the sticky error flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign outstanding = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// Directed testbench for riscv_axi_rd_arb (default parameters, MAX_OUT=4).
// Inputs change on the falling edge; outputs are checked 1ns later.

module tb_riscv_axi_rd_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int CW     = 3;

    logic                ACLK;
    logic                ARESETn;
    logic [1:0]          req_arvalid;
    logic [1:0]          req_arready;
    logic [2*ADDR_W-1:0] req_araddr;
    logic [5:0]          req_arprot;
    logic [1:0]          req_rvalid;
    logic [1:0]          req_rready;
    logic [DATA_W-1:0]   req_rdata;
    logic [1:0]          req_rresp;
    logic                m_arvalid;
    logic                m_arready;
    logic [ADDR_W-1:0]   m_araddr;
    logic [2:0]          m_arprot;
    logic [ID_W-1:0]     m_arid;
    logic [7:0]          m_arlen;
    logic [2:0]          m_arsize;
    logic [1:0]          m_arburst;
    logic                m_rvalid;
    logic                m_rready;
    logic [ID_W-1:0]     m_rid;
    logic [DATA_W-1:0]   m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rlast;
    logic [2*CW-1:0]     outstanding;
    logic                err;

    int n_assert = 0;
    int n_fail   = 0;

    riscv_axi_rd_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(4)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arprot(req_arprot),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .req_rdata(req_rdata), .req_rresp(req_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .outstanding(outstanding), .err(err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req_arvalid = 2'b00;
        req_araddr  = '0;
        req_arprot  = '0;
        req_rready  = 2'b00;
        m_arready   = 1'b0;
        m_rvalid    = 1'b0;
        m_rid       = '0;
        m_rdata     = '0;
        m_rresp     = 2'b00;
        m_rlast     = 1'b1;
    endtask

    task automatic idle();
        @(negedge ACLK);
        clear_inputs();
        #1;
    endtask

    // One AR grant: grant cycle, ISSUE cycle, then `wt` extra ISSUE cycles.
    task automatic issue(input logic [1:0] vld, input logic exp_g, input int wt,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [2:0] p0, input logic [2:0] p1);
        @(negedge ACLK);
        m_rvalid    = 1'b0;
        m_arready   = 1'b0;
        req_arvalid = vld;
        req_araddr  = {a1, a0};
        req_arprot  = {p1, p0};
        #1;
        chk("grant_arready", req_arready, exp_g ? 2'b10 : 2'b01);
        @(negedge ACLK);
        req_araddr = ~{a1, a0};
        req_arprot = ~{p1, p0};
        m_arready  = (wt == 0);
        #1;
        chk("issue_arvalid", m_arvalid, 1'b1);
        chk("issue_arid", m_arid, {3'b000, exp_g});
        chk("issue_araddr", m_araddr, exp_g ? a1 : a0);
        chk("issue_arprot", m_arprot, exp_g ? p1 : p0);
        chk("issue_arready_low", req_arready, 2'b00);
        for (int k = 0; k < wt; k++) begin
            @(negedge ACLK);
            m_arready = (k == wt - 1);
            #1;
            chk("issue_hold_arvalid", m_arvalid, 1'b1);
            chk("issue_hold_araddr", m_araddr, exp_g ? a1 : a0);
        end
    endtask

    // One R beat presented for a cycle, with expected routing.
    task automatic rbeat(input logic [3:0] rid, input logic [1:0] rr, input logic last,
                         input logic [31:0] data, input logic [1:0] exp_rv, input logic exp_mr);
        @(negedge ACLK);
        req_arvalid = 2'b00;
        m_arready   = 1'b0;
        m_rvalid    = 1'b1;
        m_rid       = rid;
        m_rdata     = data;
        m_rresp     = data[1:0];
        m_rlast     = last;
        req_rready  = rr;
        #1;
        chk("r_rvalid", req_rvalid, exp_rv);
        chk("r_mready", m_rready, exp_mr);
        chk("r_rdata", req_rdata, data);
        chk("r_rresp", req_rresp, data[1:0]);
    endtask

    initial begin
        clear_inputs();
        ARESETn = 1'b0;

        // Reset values and constant AR fields
        #12;
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_araddr", m_araddr, 32'h0);
        chk("rst_arprot", m_arprot, 3'h0);
        chk("rst_arid", m_arid, 4'h0);
        chk("rst_arready", req_arready, 2'b00);
        chk("rst_outstanding", outstanding, 6'o00);
        chk("rst_err", err, 1'b0);
        chk("arlen", m_arlen, 8'd0);
        chk("arsize", m_arsize, 3'd2);
        chk("arburst", m_arburst, 2'b01);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Single IFU read with delayed m_arready
        issue(2'b10, 1'b1, 2, 32'h0, 32'h100, 3'd0, 3'd2);
        idle();
        chk("ifu_out_after_ar", outstanding, 6'o10);
        rbeat(4'd1, 2'b10, 1'b1, 32'hDEADBEEF, 2'b10, 1'b1);
        idle();
        chk("ifu_out_after_r", outstanding, 6'o00);
        chk("ifu_err", err, 1'b0);

        // Both valid: grants alternate 0,1,0,1..., one AR every two cycles
        for (int n = 0; n < 8; n++)
            issue(2'b11, n[0], 0, 32'h1000 + n, 32'h2000 + n, 3'd1, 3'd4);
        idle();
        chk("alt_out_full", outstanding, 6'o44);

        // Drain IFU only; EXU stays at MAX_OUT
        for (int n = 0; n < 4; n++)
            rbeat(4'd1, 2'b11, 1'b1, 32'h5000 + n, 2'b10, 1'b1);
        idle();
        chk("drain_ifu_out", outstanding, 6'o04);

        // EXU blocked at 4: IFU keeps getting grants despite rr_ptr=0
        issue(2'b11, 1'b1, 0, 32'h3000, 32'h4000, 3'd0, 3'd0);
        issue(2'b11, 1'b1, 0, 32'h3004, 32'h4004, 3'd0, 3'd0);
        idle();
        chk("blocked_out", outstanding, 6'o24);
        rbeat(4'd0, 2'b01, 1'b1, 32'h0BAD_F00D, 2'b01, 1'b1);
        issue(2'b11, 1'b0, 0, 32'h3008, 32'h4008, 3'd3, 3'd0);
        idle();
        chk("resume_out", outstanding, 6'o24);

        // Reset between scenarios
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        chk("rst2_out", outstanding, 6'o00);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Out-of-order R, back-pressure from owner
        issue(2'b11, 1'b0, 0, 32'hA0, 32'hB0, 3'd0, 3'd0);
        issue(2'b11, 1'b1, 0, 32'hA4, 32'hB4, 3'd0, 3'd0);
        rbeat(4'd1, 2'b00, 1'b1, 32'h1111_0001, 2'b10, 1'b0);
        rbeat(4'd1, 2'b10, 1'b1, 32'h1111_0001, 2'b10, 1'b1);
        rbeat(4'd0, 2'b01, 1'b1, 32'h2222_0000, 2'b01, 1'b1);
        idle();
        chk("ooo_out", outstanding, 6'o00);
        chk("ooo_err", err, 1'b0);

        // Same-cycle AR handshake and R completion for EXU at outstanding 2
        issue(2'b01, 1'b0, 0, 32'hC0, 32'h0, 3'd0, 3'd0);
        issue(2'b01, 1'b0, 0, 32'hC4, 32'h0, 3'd0, 3'd0);
        @(negedge ACLK);
        clear_inputs();
        req_arvalid = 2'b01;
        #1;
        chk("same_grant", req_arready, 2'b01);
        @(negedge ACLK);
        req_arvalid = 2'b00;
        m_arready   = 1'b1;
        m_rvalid    = 1'b1;
        m_rid       = 4'd0;
        m_rdata     = 32'h3333_3333;
        m_rlast     = 1'b1;
        req_rready  = 2'b01;
        #1;
        chk("same_arvalid", m_arvalid, 1'b1);
        chk("same_rvalid", req_rvalid, 2'b01);
        idle();
        chk("same_out", outstanding, 6'o02);
        chk("same_err", err, 1'b0);
        rbeat(4'd0, 2'b01, 1'b1, 32'h4444_0000, 2'b01, 1'b1);
        rbeat(4'd0, 2'b01, 1'b1, 32'h4444_0004, 2'b01, 1'b1);
        idle();
        chk("same_drain_out", outstanding, 6'o00);

        // Unexpected RID=0 with nothing outstanding: dropped, err sticky
        rbeat(4'd0, 2'b00, 1'b1, 32'h5555_5555, 2'b00, 1'b1);
        idle();
        chk("unexp_err", err, 1'b1);
        chk("unexp_out", outstanding, 6'o00);
        idle();
        chk("unexp_err_held", err, 1'b1);

        // Reset asserted while ISSUE is pending
        @(negedge ACLK);
        clear_inputs();
        req_arvalid = 2'b10;
        @(negedge ACLK);
        #1;
        chk("rstiss_arvalid_pre", m_arvalid, 1'b1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("rstiss_arvalid", m_arvalid, 1'b0);
        chk("rstiss_err", err, 1'b0);
        chk("rstiss_arready", req_arready, 2'b00);
        @(negedge ACLK);
        clear_inputs();
        ARESETn = 1'b1;

        // Missing RLAST: routed and counted, but flags err
        issue(2'b10, 1'b1, 0, 32'h0, 32'h700, 3'd0, 3'd5);
        rbeat(4'd1, 2'b10, 1'b0, 32'h6666_6666, 2'b10, 1'b1);
        idle();
        chk("nolast_out", outstanding, 6'o00);
        chk("nolast_err", err, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
